// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and constants for the cache-line / memory-burst adaptor.
package cacheline_adaptor_types;

  localparam int unsigned S_BEAT    = 64;
  localparam int unsigned NUM_BEATS = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Cacheline adaptor: turns one cache-line read/write request into a
// four-beat memory burst and returns a single-cycle completion pulse.
module cacheline_adaptor
  import cacheline_adaptor_types::*;
#(
  parameter int unsigned s_line    = 256,
  parameter int unsigned s_beat    = S_BEAT,
  parameter int unsigned num_beats = s_line / s_beat
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       address_i,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [s_line-1:0] line_i,
  output logic [s_line-1:0] line_o,
  output logic              resp_o,
  output logic [31:0]       address_o,
  output logic              read_o,
  output logic              write_o,
  output logic [s_beat-1:0] burst_o,
  input  logic [s_beat-1:0] burst_i,
  input  logic              resp_i
);

  localparam int unsigned CNT_W = $clog2(num_beats);
  localparam int unsigned OFF_W = $clog2(s_line / 8);

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic [s_line-1:0]  wline;
  logic               last_beat;
  logic [OFF_W-1:0]   unused_offset;

  // Byte offset within the line is dropped by the line-aligned address.
  assign unused_offset = address_i[OFF_W-1:0];
  assign last_beat     = resp_i && (cnt == CNT_W'(num_beats - 1));

  // Write beat presented to memory is the latched word selected by the counter.
  assign burst_o = wline[cnt*s_beat +: s_beat];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; write takes priority over read when both are pending.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (write_i)     next_state = WRITE;
        else if (read_i) next_state = READ;
      end
      READ, WRITE: begin
        if (last_beat) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Control outputs registered from next_state so they line up with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_o  <= 1'b0;
      write_o <= 1'b0;
      resp_o  <= 1'b0;
    end else begin
      read_o  <= (next_state == READ);
      write_o <= (next_state == WRITE);
      resp_o  <= (next_state == DONE);
    end
  end

  // Datapath: request latching, beat counting and read-line assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      wline     <= '0;
      address_o <= '0;
      line_o    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (write_i) begin
            wline     <= line_i;
            address_o <= {address_i[31:OFF_W], {OFF_W{1'b0}}};
          end else if (read_i) begin
            address_o <= {address_i[31:OFF_W], {OFF_W{1'b0}}};
          end
        end
        READ: begin
          if (resp_i) begin
            line_o[cnt*s_beat +: s_beat] <= burst_i;
            cnt                          <= cnt + CNT_W'(1);
          end
        end
        WRITE: begin
          if (resp_i) cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed scenarios plus
// randomized bursts checked against a line/beat reference model.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i;
  logic         resp_i;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [255:0] last_line;

  cacheline_adaptor #(
    .s_line (256),
    .s_beat (64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int j = 0; j < 8; j++) l[j*32 +: 32] = $urandom;
    return l;
  endfunction

  // One full burst. Request inputs must already be driven before the call.
  // mode 0: contiguous beats, random data
  // mode 1: random gaps, request dropped mid-burst, resp_i noise in DONE
  // mode 2: beat pattern 1,0,0,1,1,0,1
  // mode 3: contiguous beats with data 0x11..,0x22..,0x33..,0x44..
  task automatic burst(input bit is_write, input bit keep_read, input int mode);
    logic [31:0]  addr;
    logic [255:0] wl;
    logic [255:0] exp_line;
    logic [63:0]  words [4];
    logic [6:0]   pat;
    logic [3:0]   d;
    bit           hi;
    int           k;
    int           cyc;
    addr = address_i;
    wl   = line_i;
    pat  = 7'b1011001;  // read LSB first: 1,0,0,1,1,0,1
    @(negedge clk);
    check("start_addr", address_o, {addr[31:5], 5'b0});
    check("start_read_o", read_o, !is_write);
    check("start_write_o", write_o, is_write);
    k   = 0;
    cyc = 0;
    while (k < 4 && cyc < 64) begin
      check("busy_resp_o", resp_o, 1'b0);
      check("busy_req_o", is_write ? write_o : read_o, 1'b1);
      check("busy_addr", address_o, {addr[31:5], 5'b0});
      if (is_write) check("burst_o_word", burst_o, wl[k*64 +: 64]);
      case (mode)
        1:       hi = ($urandom_range(0, 2) != 0);
        2:       hi = pat[cyc % 7];
        default: hi = 1'b1;
      endcase
      resp_i = hi;
      if (mode == 3) begin
        d       = 4'(k + 1);
        burst_i = {16{d}};
      end else begin
        burst_i = {$urandom, $urandom};
      end
      if (hi) begin
        words[k] = burst_i;
        k++;
      end
      if (mode == 1 && cyc == 1) begin
        read_i  = 1'b0;
        write_i = 1'b0;
        line_i  = rand_line();
      end
      cyc++;
      @(negedge clk);
    end
    check("beats_done", 32'(k), 32'd4);
    for (int j = 0; j < 4; j++) exp_line[j*64 +: 64] = words[j];
    resp_i = 1'b0;
    check("done_resp_o", resp_o, 1'b1);
    check("done_read_o", read_o, 1'b0);
    check("done_write_o", write_o, 1'b0);
    if (!is_write) begin
      check("done_line_o", line_o, exp_line);
      last_line = exp_line;
    end
    if (!keep_read) read_i = 1'b0;
    write_i = 1'b0;
    if (mode == 1) begin
      resp_i  = 1'($urandom_range(0, 1));
      burst_i = {$urandom, $urandom};
    end
    @(negedge clk);
    resp_i = 1'b0;
    check("post_resp_o", resp_o, 1'b0);
    check("post_line_o", line_o, last_line);
  endtask

  initial begin
    rst_n     = 1'b0;
    address_i = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    line_i    = '0;
    burst_i   = '0;
    resp_i    = 1'b0;
    last_line = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_read_o", read_o, 1'b0);
    check("rst_write_o", write_o, 1'b0);
    check("rst_resp_o", resp_o, 1'b0);
    check("rst_address_o", address_o, 32'h0);
    check("rst_line_o", line_o, '0);
    check("rst_burst_o", burst_o, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed read with known beat data and aligned address.
    address_i = 32'h0000_1234;
    read_i    = 1'b1;
    burst(1'b0, 1'b0, 3);
    check("rd_addr_1220", address_o, 32'h0000_1220);
    check("rd_line_fixed", line_o,
          {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

    // Directed write with four distinct words.
    address_i = 32'h0000_8040;
    line_i    = {64'hAAAA_AAAA_AAAA_AAAA, 64'hCCCC_CCCC_CCCC_CCCC,
                 64'hDDDD_DDDD_DDDD_DDDD, 64'hBBBB_BBBB_BBBB_BBBB};
    write_i   = 1'b1;
    burst(1'b1, 1'b0, 0);

    // Gapped read.
    address_i = 32'hCAFE_0013;
    read_i    = 1'b1;
    burst(1'b0, 1'b0, 2);

    // Simultaneous write and read: write first, then the held read.
    address_i = 32'h0001_00FF;
    line_i    = rand_line();
    write_i   = 1'b1;
    read_i    = 1'b1;
    burst(1'b1, 1'b1, 0);
    burst(1'b0, 1'b0, 0);

    // Spurious memory strobes while idle.
    for (int i = 0; i < 3; i++) begin
      resp_i  = 1'b1;
      burst_i = {$urandom, $urandom};
      @(negedge clk);
      check("idle_line_o", line_o, last_line);
      check("idle_resp_o", resp_o, 1'b0);
      check("idle_read_o", read_o, 1'b0);
    end
    resp_i = 1'b0;
    @(negedge clk);

    // Reset in the middle of a read burst.
    address_i = 32'hDEAD_BEEF;
    read_i    = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      resp_i  = 1'b1;
      burst_i = {$urandom, $urandom};
      @(negedge clk);
    end
    resp_i = 1'b0;
    read_i = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("mid_rst_read_o", read_o, 1'b0);
    check("mid_rst_resp_o", resp_o, 1'b0);
    check("mid_rst_address_o", address_o, 32'h0);
    check("mid_rst_line_o", line_o, '0);
    check("mid_rst_burst_o", burst_o, 64'h0);
    last_line = '0;
    @(negedge clk);
    check("rst_hold_resp_o", resp_o, 1'b0);
    rst_n     = 1'b1;
    address_i = 32'h0000_7777;
    read_i    = 1'b1;
    burst(1'b0, 1'b0, 0);

    // Randomized bursts.
    for (int i = 0; i < 10; i++) begin
      address_i = $urandom;
      line_i    = rand_line();
      if ($urandom_range(0, 1) == 1) write_i = 1'b1;
      else                           read_i  = 1'b1;
      burst(write_i, 1'b0, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
